// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler that shares one serial DAC between two sample requesters
// and generates the complete 32-bit SPI write-and-update frame.
module dac_update_scheduler #(
  parameter int         SCK_HALF = 2,
  parameter logic [3:0] CMD      = 4'b0011,
  parameter logic [3:0] ADDR_A   = 4'b0000,
  parameter logic [3:0] ADDR_B   = 4'b0001,
  parameter int         CS_GAP   = 2
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [11:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [11:0] data_b,
  output logic        ack_b,
  output logic        busy,
  output logic        frame_done,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  output logic        DAC_CS,
  output logic        DAC_CLR
);

  // state | meaning
  // IDLE  | CS high, waiting for a request, arbitrates on each edge
  // SHIFT | CS low, clocking out 32 bits MSB first
  // GAP   | CS high for CS_GAP cycles before the next grant

  localparam int PW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SCK_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase;
  logic [4:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   shift_reg;
  logic [31:0]   word;
  logic          rr_last;  // 1: B won last, so A has priority
  logic          grant_a, grant_b, phase_end, last_fall;

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_a || grant_b) state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    grant_a   = (state == IDLE) && req_a && (!req_b || rr_last);
    grant_b   = (state == IDLE) && req_b && (!req_a || !rr_last);
    phase_end = (phase == PHASE_LAST);
    last_fall = (state == SHIFT) && phase_end && SPI_SCK && (bit_cnt == 5'd31);
    word      = grant_a ? {8'h00, CMD, ADDR_A, data_a, 4'h0}
                        : {8'h00, CMD, ADDR_B, data_b, 4'h0};
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      frame_done <= 1'b0;
      SPI_SCK    <= 1'b0;
      SPI_MOSI   <= 1'b0;
      DAC_CS     <= 1'b1;
      DAC_CLR    <= 1'b0;
      rr_last    <= 1'b1;
      phase      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      frame_done <= 1'b0;
      DAC_CLR    <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            ack_a     <= grant_a;
            ack_b     <= grant_b;
            rr_last   <= grant_b;
            shift_reg <= word;
            SPI_MOSI  <= word[31];
            SPI_SCK   <= 1'b0;
            DAC_CS    <= 1'b0;
            phase     <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            phase <= '0;
            if (!SPI_SCK) begin
              SPI_SCK <= 1'b1;
            end else if (bit_cnt == 5'd31) begin
              SPI_SCK    <= 1'b0;
              SPI_MOSI   <= 1'b0;
              DAC_CS     <= 1'b1;
              frame_done <= 1'b1;
              gap_cnt    <= '0;
            end else begin
              // falling SCK: advance to the next bit so it settles before the rise
              SPI_SCK   <= 1'b0;
              bit_cnt   <= bit_cnt + 5'd1;
              shift_reg <= {shift_reg[30:0], 1'b0};
              SPI_MOSI  <= shift_reg[30];
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
